// File: rtl/asyn_fifo_wr_arb_if.sv
// Shared write-port bundle between the requesters/FIFO side (master) and the
// round-robin write arbiter (slave).
interface asyn_fifo_wr_arb_if #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  wfull;
    logic [NREQ-1:0]       gnt;
    logic [ID_W-1:0]       gnt_id;
    logic [NREQ-1:0]       ack;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;

    modport master (
        output req, req_data, wfull,
        input  gnt, gnt_id, ack, winc, wdata
    );

    modport slave (
        input  req, req_data, wfull,
        output gnt, gnt_id, ack, winc, wdata
    );
endinterface

// File: rtl/asyn_fifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO write port between NREQ requesters.
// Define ASYN_FIFO_WR_ARB_BURST_EN to let an owner keep the port for up to BURST words.
module asyn_fifo_wr_arb #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    asyn_fifo_wr_arb_if.slave  bus
);
    localparam int ID_W = $clog2(NREQ);

    if (BURST < 1 || NREQ < 2 || NREQ > 16) begin : g_param_chk
        $error("asyn_fifo_wr_arb: NREQ must be 2..16 and BURST >= 1");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] win;
    logic [NREQ-1:0] ack;
    logic            any_req;
    logic            own_req;
    logic            own_ack;
    logic            last_beat;
    logic            release_now;
    logic [DSIZE-1:0] wdata;

    // Nearest requester after prev (wrapping); prev itself is considered last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [ID_W-1:0] prev);
        logic [ID_W-1:0] sel;
        int              best;
        int              d;
        sel  = prev;
        best = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            d = j - int'(prev) - 1;
            if (d < 0) d = d + NREQ;
            if (r[j] && d < best) begin
                best = d;
                sel  = ID_W'(j);
            end
        end
        return sel;
    endfunction

    assign win     = rr_pick(bus.req, last);
    assign any_req = |bus.req;
    assign ack     = gnt & bus.req & {NREQ{~bus.wfull}};
    assign own_req = |(gnt & bus.req);
    assign own_ack = |ack;

`ifdef ASYN_FIFO_WR_ARB_BURST_EN
    localparam int              CNT_W    = $clog2(BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
    logic [CNT_W-1:0] cnt;
    assign last_beat = (cnt == CNT_LAST);
`else
    assign last_beat = 1'b1;
`endif

    // Idle is treated as "released" so a fresh request arbitrates the same way.
    assign release_now = (state == IDLE) || !own_req || (own_ack && last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            last   <= ID_W'(NREQ - 1);
`ifdef ASYN_FIFO_WR_ARB_BURST_EN
            cnt    <= '0;
`endif
        end else if (release_now) begin
            if (any_req) begin
                state  <= OWN;
                gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                gnt_id <= win;
                last   <= win;
            end else begin
                state  <= IDLE;
                gnt    <= '0;
                gnt_id <= '0;
            end
`ifdef ASYN_FIFO_WR_ARB_BURST_EN
            cnt <= '0;
`endif
        end else if (own_ack) begin
`ifdef ASYN_FIFO_WR_ARB_BURST_EN
            cnt <= cnt + CNT_W'(1);
`endif
        end
    end

    always_comb begin
        wdata = bus.req_data[DSIZE-1:0];
        for (int j = 1; j < NREQ; j++) begin
            if (gnt_id == ID_W'(j)) wdata = bus.req_data[j*DSIZE +: DSIZE];
        end
    end

    assign bus.gnt    = gnt;
    assign bus.gnt_id = gnt_id;
    assign bus.ack    = ack;
    assign bus.winc   = own_ack;
    assign bus.wdata  = wdata;
endmodule

// File: doc/asyn_fifo_wr_arb.md
# asyn_fifo_wr_arb

Round-robin write-port arbiter sitting in the write clock domain in front of the asynchronous FIFO. It shares the single FIFO write port (winc/wdata, back-pressured by wfull) between NREQ requesters, grants one requester at a time, and optionally lets the owner keep the port for a bounded burst. All state is registered on clk; the FIFO side sees at most one write per cycle and never sees a write while wfull is high.

## Interface
- DSIZE, 8, data width; must equal the FIFO DSIZE.
- NREQ, 4, number of requesters, 2..16.
- BURST, 4, maximum words per grant, >=1; used only with the burst feature compiled in.
- clk  input  1  write-domain clock; the FIFO write clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester write request; held high while the requester has a word to write.
- req_data  input  NREQ*DSIZE  packed write data; requester i occupies bits [i*DSIZE +: DSIZE].
- wfull  input  1  FIFO full flag, from the FIFO write domain.
- gnt  output  NREQ  registered one-hot grant; all-zero when idle.
- gnt_id  output  log2(NREQ)  registered index of the owner; 0 when idle.
- ack  output  NREQ  combinational: gnt & req & {NREQ{~wfull}}; the word is consumed this cycle.
- winc  output  1  combinational: |ack; connects to the FIFO winc.
- wdata  output  DSIZE  combinational: the req_data slice selected by gnt_id; connects to the FIFO wdata.

## Operation
- States: IDLE (gnt=0) and OWN (exactly one gnt bit set). Internal registers: gnt, gnt_id, last (last owner, reset value NREQ-1), and beat counter cnt (width log2(BURST)+1, reset value 0).
- Winner selection: first set bit of req scanning last+1, last+2, ... with wrap modulo NREQ. The previous owner is eligible but has the lowest priority.
- IDLE: if req!=0, go to OWN at the next edge with the selected winner. cnt=0, last=winner.
- OWN, each edge:
  - Release condition: req[gnt_id]==0, or (ack[gnt_id] and cnt==BURST-1).
  - On release, if any req bit is set, rearbitrate in the same edge: the new winner is taken directly, with no idle cycle. cnt=0 and last=winner. Otherwise go to IDLE.
  - No release: if ack, cnt increments. While wfull is high, ack=0, cnt holds, and the grant holds.
- Requester contract: keep req and data stable until ack. The requester may drop req only after ack, or while not granted.
- Dropping req while granted without an ack is legal. It releases the grant at the next edge with no write.
- wfull is evaluated combinationally each cycle. A write never occurs while wfull=1.

## Timing
- Reset values: gnt=0, gnt_id=0, ack=0, winc=0, wdata=req_data[DSIZE-1:0]. Reset assertion mid-burst clears gnt asynchronously, so winc falls in the same cycle.
- Latency: req rising in IDLE is sampled at edge N, and gnt is high after edge N. The first ack is in cycle N+1 if wfull=0.
- Throughput: one word per cycle while the owner holds req and wfull=0.
- Handoff: the new owner's gnt appears after the edge that accepted the previous owner's last word, giving zero bubble cycles.
- Simultaneous events:
  - The last burst word accepted while other requests are pending gives a handoff.
  - wfull rising in the cycle the owner drops req gives release with no write.
  - When all req bits are set, service order from reset is 0,1,2,...,NREQ-1,0.

## Configuration
- ASYN_FIFO_WR_ARB_BURST_EN defined: burst lock as described; the owner keeps the port for up to BURST accepted words.
- ASYN_FIFO_WR_ARB_BURST_EN undefined: BURST is ignored and the block behaves as BURST=1. The grant is released after every accepted word, giving strict per-word round-robin. The cnt register is not built.

## Test plan
- Reset and idle: assert rst with req=4'b1111 -> gnt=0 and winc=0. Release rst, with burst enabled and BURST=4 -> gnt=4'b0001 one cycle later. Words 0..3 come from requester 0, then gnt=4'b0010 with no bubble.
- Single requester, BURST=4, req[2] held for 10 words with wfull=0 -> 4 writes, handoff to requester 2 again (sole requester), 10 consecutive winc cycles in total.
- Back-pressure: requester 1 granted, wfull=1 for 3 cycles mid-burst -> winc=0 for those 3 cycles, cnt frozen, burst completes its remaining words after wfull=0.
- Early drop: requester 3 granted, drops req before any ack -> no write; the grant moves to the next pending requester (or IDLE) after one edge.
- Macro undefined, req=4'b1011 constant, wfull=0 -> grant sequence 0,1,3,0,1,3 with one word each, winc high every cycle.
- Async reset asserted mid-burst at the 2nd word -> gnt and winc low within the same cycle. After release, arbitration restarts from requester 0.
